// File: rtl/togg_det_if.sv
// Bundles togg_det's control inputs and edge-event outputs.
// The master drives enable/trigger/count_clr; the slave (detector) returns pulses and count.
interface togg_det_if #(
  parameter int unsigned COUNT_WIDTH = 8
);
  logic                   enable;
  logic                   trigger;
  logic                   count_clr;
  logic                   toggle_pulse;
  logic                   rise_pulse;
  logic                   fall_pulse;
  logic [COUNT_WIDTH-1:0] toggle_count;

  modport master (
    output enable,
    output trigger,
    output count_clr,
    input  toggle_pulse,
    input  rise_pulse,
    input  fall_pulse,
    input  toggle_count
  );

  modport slave (
    input  enable,
    input  trigger,
    input  count_clr,
    output toggle_pulse,
    output rise_pulse,
    output fall_pulse,
    output toggle_count
  );
endinterface

// File: rtl/togg_det.sv
// Any-edge detector on a single control level with rise/fall pulses and a saturating
// toggle counter; an optional flop chain brings trigger in from another clock domain.
module togg_det #(
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned COUNT_WIDTH = 8
) (
  input logic        clk,
  input logic        rst_n,
  togg_det_if.slave  bus
);

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  typedef enum logic {
    ST_PRIME = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic                   trig_s;
  logic                   trig_q;
  logic                   toggle_q;
  logic                   rise_q;
  logic                   fall_q;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic                   toggle_d;
  logic                   rise_d;
  logic                   fall_d;
  logic [COUNT_WIDTH-1:0] cnt_d;

  // Synchronizer chain; zero stages passes trigger straight through.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign trig_s = bus.trigger;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.trigger;
          for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign trig_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_PRIME;
      trig_q   <= 1'b0;
      toggle_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      trig_q   <= trig_s;
      toggle_q <= toggle_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  // The first edge out of reset only loads trig_q, so no stale comparison can fire.
  always_comb begin
    state_d  = state_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = 1'b0;
    cnt_d    = cnt_q;

    if (state_q == ST_PRIME) begin
      state_d = ST_RUN;
    end else begin
      rise_d   = bus.enable &  trig_s & ~trig_q;
      fall_d   = bus.enable & ~trig_s &  trig_q;
      toggle_d = rise_d | fall_d;
    end

    if (bus.count_clr) begin
      cnt_d = '0;
    end else if (toggle_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  assign bus.toggle_pulse = toggle_q;
  assign bus.rise_pulse   = rise_q;
  assign bus.fall_pulse   = fall_q;
  assign bus.toggle_count = cnt_q;

endmodule

// File: tb/tb_togg_det.sv
// Drives three togg_det configurations from one stimulus stream and checks every output
// each cycle against an edge-history reference model.
module tb_togg_det;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic trigger = 1'b0;
  logic count_clr = 1'b0;

  always #5 clk = ~clk;

  togg_det_if #(.COUNT_WIDTH(8)) bus0 ();
  togg_det_if #(.COUNT_WIDTH(2)) bus1 ();
  togg_det_if #(.COUNT_WIDTH(8)) bus2 ();

  assign bus0.enable = enable;  assign bus0.trigger = trigger;  assign bus0.count_clr = count_clr;
  assign bus1.enable = enable;  assign bus1.trigger = trigger;  assign bus1.count_clr = count_clr;
  assign bus2.enable = enable;  assign bus2.trigger = trigger;  assign bus2.count_clr = count_clr;

  togg_det #(.SYNC_STAGES(0), .COUNT_WIDTH(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  togg_det #(.SYNC_STAGES(0), .COUNT_WIDTH(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  togg_det #(.SYNC_STAGES(2), .COUNT_WIDTH(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic        obs_t [3];
  logic        obs_r [3];
  logic        obs_f [3];
  logic [31:0] obs_c [3];

  assign obs_t[0] = bus0.toggle_pulse; assign obs_r[0] = bus0.rise_pulse;
  assign obs_f[0] = bus0.fall_pulse;   assign obs_c[0] = 32'(bus0.toggle_count);
  assign obs_t[1] = bus1.toggle_pulse; assign obs_r[1] = bus1.rise_pulse;
  assign obs_f[1] = bus1.fall_pulse;   assign obs_c[1] = 32'(bus1.toggle_count);
  assign obs_t[2] = bus2.toggle_pulse; assign obs_r[2] = bus2.rise_pulse;
  assign obs_f[2] = bus2.fall_pulse;   assign obs_c[2] = 32'(bus2.toggle_count);

  // Reference model: per-edge history of sampled inputs since time zero.
  localparam int HIST = 4096;
  int  stages [3] = '{0, 0, 2};
  int  cmax   [3] = '{255, 3, 255};
  bit  trig_h [HIST];
  bit  en_h   [HIST];
  int  ecnt = 0;
  int  rst_edge = -1;
  bit  exp_t [3];
  bit  exp_r [3];
  bit  exp_f [3];
  int  exp_c [3];

  int tests = 0;
  int fails = 0;

  // Level the detector sees at edge k: trigger from S edges earlier, zero if that edge predates release.
  function automatic bit seen(input int k, input int s);
    int idx = k - s;
    if (idx < 0 || idx <= rst_edge) return 1'b0;
    return trig_h[idx];
  endfunction

  task automatic model_edge();
    int k = ecnt;
    trig_h[k] = trigger;
    en_h[k]   = enable;
    if (!rst_n) begin
      rst_edge = k;
      for (int i = 0; i < 3; i++) begin
        exp_t[i] = 0; exp_r[i] = 0; exp_f[i] = 0; exp_c[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        bit primed = (k > rst_edge + 1);
        bit cur = seen(k, stages[i]);
        bit prv = seen(k - 1, stages[i]);
        exp_r[i] = primed && en_h[k] && cur && !prv;
        exp_f[i] = primed && en_h[k] && !cur && prv;
        exp_t[i] = exp_r[i] || exp_f[i];
        if (count_clr) exp_c[i] = 0;
        else if (exp_t[i] && exp_c[i] < cmax[i]) exp_c[i] = exp_c[i] + 1;
      end
    end
    ecnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ecnt - 1);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dut%0d.toggle", i), 32'(obs_t[i]), 32'(exp_t[i]));
      chk($sformatf("dut%0d.rise", i),   32'(obs_r[i]), 32'(exp_r[i]));
      chk($sformatf("dut%0d.fall", i),   32'(obs_f[i]), 32'(exp_f[i]));
      chk($sformatf("dut%0d.count", i),  obs_c[i],      32'(exp_c[i]));
    end
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic t, input logic c);
    @(negedge clk);
    rst_n = r; enable = e; trigger = t; count_clr = c;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    // Reset values
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("rst.toggle0", 32'(obs_t[0]), 32'd0);
    chk("rst.count0", obs_c[0], 32'd0);

    // Basic toggles, including a rewrite of the same level
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("basic.rise0", 32'(obs_r[0]), 32'd1);
    chk("basic.tog0", 32'(obs_t[0]), 32'd1);
    step(1, 1, 1, 0);
    chk("basic.held0", 32'(obs_t[0]), 32'd0);
    step(1, 1, 0, 0);
    chk("basic.fall0", 32'(obs_f[0]), 32'd1);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    step(1, 1, 1, 0);
    chk("basic.rewrite0", 32'(obs_t[0]), 32'd0);
    step(1, 1, 1, 0);
    step(1, 1, 0, 0);
    chk("basic.count4", obs_c[0], 32'd4);
    step(1, 1, 1, 0);
    chk("sat.count_w2", obs_c[1], 32'd3);
    chk("basic.count5", obs_c[0], 32'd5);

    // Clear wins over a coincident toggle
    step(1, 1, 0, 1);
    chk("clr.toggle1", 32'(obs_t[1]), 32'd1);
    chk("clr.count1", obs_c[1], 32'd0);
    chk("clr.count0", obs_c[0], 32'd0);

    // Priming: trigger high through reset and after release
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 0);
      chk("prime.toggle0", 32'(obs_t[0]), 32'd0);
    end
    chk("prime.count0", obs_c[0], 32'd0);

    // Enable gating: changes while disabled are never reported
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    chk("gate.toggle0", 32'(obs_t[0]), 32'd0);
    step(1, 1, 0, 0);
    chk("gate.steady0", 32'(obs_t[0]), 32'd0);
    chk("gate.count0", obs_c[0], 32'd0);

    // Two-stage synchronizer adds two cycles of latency
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("sync.n0", 32'(obs_t[2]), 32'd0);
    step(1, 1, 1, 0);
    chk("sync.n1", 32'(obs_t[2]), 32'd0);
    step(1, 1, 1, 0);
    chk("sync.n2_tog", 32'(obs_t[2]), 32'd1);
    chk("sync.n2_rise", 32'(obs_r[2]), 32'd1);
    step(1, 1, 1, 0);
    chk("sync.n3", 32'(obs_t[2]), 32'd0);

    // Reset while a pulse is high
    step(1, 1, 0, 0);
    chk("midrst.pulse0", 32'(obs_t[0]), 32'd1);
    step(0, 1, 0, 0);
    chk("midrst.toggle0", 32'(obs_t[0]), 32'd0);
    chk("midrst.count0", obs_c[0], 32'd0);
    step(1, 1, 1, 0);
    chk("midrst.prime0", 32'(obs_t[0]), 32'd0);
    step(1, 1, 1, 0);
    chk("midrst.after0", 32'(obs_t[0]), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      step(logic'($urandom_range(0, 49) != 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/togg_det.md
Name: togg_det

Overview:
- Single-bit toggle (any-edge) detector for a synchronous control input.
- Emits a one-clock pulse for every change of `trigger` level, plus separate rise/fall pulses and a saturating toggle counter.
- Used as an edge-event source for downstream control logic and for activity monitoring.
- Optional input synchronizer allows `trigger` to come from another clock domain.

Parameters:
- SYNC_STAGES, 0, number of flip-flop synchronizer stages ahead of detection. 0 = trigger is already synchronous to clk. Legal range 0..4.
- COUNT_WIDTH, 8, width of toggle_count. Legal range 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- enable  input  1  when 0, detection pulses are suppressed; sampling continues
- trigger  input  1  monitored level
- count_clr  input  1  synchronous clear of toggle_count
- toggle_pulse  output  1  registered; high for exactly one cycle per detected level change
- rise_pulse  output  1  registered; one-cycle pulse on a 0->1 change
- fall_pulse  output  1  registered; one-cycle pulse on a 1->0 change
- toggle_count  output  COUNT_WIDTH  number of detected toggles, saturating

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Clock and reset:
  - All state updates on the rising edge of clk.
  - Reset is sampled only at a clk edge while rst_n=0.
- Reset values:
  - toggle_pulse, rise_pulse, fall_pulse = 0.
  - toggle_count = 0.
  - Synchronizer stages = 0, previous-sample register = 0.
  - Internal primed flag = 0.
- Sampling path:
  - trig_s is trigger delayed through SYNC_STAGES flops. With SYNC_STAGES=0, trig_s is trigger itself.
  - Each edge: trig_q <= trig_s and primed <= 1.
- Priming:
  - The first edge after reset release (primed=0) only loads trig_q.
  - No pulse is produced on that edge, whatever the level of trigger.
- Detection, on each edge with rst_n=1 and primed=1:
  - toggle_pulse <= enable & (trig_s != trig_q)
  - rise_pulse <= enable & trig_s & ~trig_q
  - fall_pulse <= enable & ~trig_s & trig_q
- Latency:
  - With SYNC_STAGES=0, a change sampled at edge N produces pulses that are high from edge N to edge N+1.
  - Each synchronizer stage adds one cycle.
- Pulse rules:
  - Pulses never last more than one cycle per sampled change.
  - A level held constant produces no further pulses.
  - A change that reverts before the next edge is not seen.
  - rise_pulse and fall_pulse are mutually exclusive.
  - toggle_pulse = rise_pulse | fall_pulse at all times.
- enable=0:
  - trig_q still tracks trig_s, so a change made while disabled is not reported later.
- toggle_count:
  - Increments by 1 in the same edge that sets toggle_pulse.
  - Saturates at 2^COUNT_WIDTH-1.
  - count_clr=1 forces it to 0 and has priority over an increment in the same cycle.
- Reset mid-operation:
  - Outputs clear on the reset edge, and primed returns to 0.
  - A change in progress across reset is discarded.

Test Plan:
1. Basic toggles (SYNC_STAGES=0, 10 ns clock, edges at 5, 15, 25… ns; rst_n=1 from t=0; enable=1):
   - trigger 0->1 at 12 ns -> toggle_pulse and rise_pulse high 15–25 ns.
   - 1->0 at 32 ns -> toggle_pulse and fall_pulse high 35–45 ns.
   - 0->1 at 52 ns -> pulse 55–65 ns.
   - Rewrite of 1 at 72 ns -> no pulse.
   - 1->0 at 92 ns -> pulse 95–105 ns.
   - Final toggle_count = 4.
2. Priming: hold trigger=1 through reset, release rst_n -> no pulse on any following edge; toggle_count stays 0.
3. Enable gating: enable=0, toggle trigger twice -> no pulses, count 0. Set enable=1 with trigger steady -> still no pulse.
4. Saturation and clear:
   - COUNT_WIDTH=2, 5 toggles -> toggle_count = 3.
   - count_clr asserted in the same cycle as a toggle -> count = 0 and toggle_pulse = 1.
5. Synchronizer latency: SYNC_STAGES=2, trigger change sampled at edge N -> pulse high from edge N+2 to edge N+3.
6. Reset mid-pulse: rst_n=0 while toggle_pulse=1 -> all outputs 0 on that edge; no pulse on the first edge after release.
